// File: rtl/fft16_addr_ctrl.sv
// Address sequencer for an in-place radix-2 DIT 16-point FFT (4 stages x 8 butterflies).
// Latency: first read 1 cycle after start; done pulse 4*(8+BF_LAT)+1 cycles after start.
// Backpressure: none; start is sampled only in IDLE and ignored while busy.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 request one FFT (sampled only in IDLE)
//   busy, done, stage     status: busy while not IDLE, done pulse, current stage 0..3
//   rd_en, rd_addr_a/b    butterfly issue strobe and input addresses
//   tw_addr               twiddle ROM index, aligned with rd_en
//   wr_en, wr_addr_a/b    write-back strobe and addresses, BF_LAT cycles after rd_en
module fft16_addr_ctrl #(
  parameter int BF_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [1:0] stage,
  output logic       rd_en,
  output logic [3:0] rd_addr_a,
  output logic [3:0] rd_addr_b,
  output logic [2:0] tw_addr,
  output logic       wr_en,
  output logic [3:0] wr_addr_a,
  output logic [3:0] wr_addr_b
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [3:0] DRAIN_LAST = 4'(BF_LAT - 1);

  state_t     state, state_nxt;
  logic [1:0] s, s_nxt;
  logic [2:0] b, b_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic [3:0] addr_a_nxt, addr_b_nxt;
  logic [2:0] tw_nxt;

  // write-back delay line: {rd_en, rd_addr_a, rd_addr_b}
  logic [8:0] wpipe [BF_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      s     <= '0;
      b     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      s     <= s_nxt;
      b     <= b_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    b_nxt     = b;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          s_nxt     = '0;
          b_nxt     = '0;
        end
      end
      RUN: begin
        if (b == 3'd7) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end else begin
          b_nxt = b + 3'd1;
        end
      end
      DRAIN: begin
        // the last write of this stage lands in the final drain cycle
        if (cnt == DRAIN_LAST) begin
          if (s == 2'd3) begin
            state_nxt = DONE;
          end else begin
            state_nxt = RUN;
            s_nxt     = s + 2'd1;
            b_nxt     = '0;
          end
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        s_nxt     = '0;
        b_nxt     = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Butterfly addresses: insert a 0 bit at position s of b for the top
  // input; the bottom input sets that bit. Twiddle = low s bits of b,
  // left-justified in 3 bits.
  always_comb begin
    addr_a_nxt = '0;
    tw_nxt     = '0;
    case (s_nxt)
      2'd0: begin
        addr_a_nxt = {b_nxt, 1'b0};
        tw_nxt     = 3'd0;
      end
      2'd1: begin
        addr_a_nxt = {b_nxt[2:1], 1'b0, b_nxt[0]};
        tw_nxt     = {b_nxt[0], 2'b00};
      end
      2'd2: begin
        addr_a_nxt = {b_nxt[2], 1'b0, b_nxt[1:0]};
        tw_nxt     = {b_nxt[1:0], 1'b0};
      end
      default: begin
        addr_a_nxt = {1'b0, b_nxt};
        tw_nxt     = b_nxt;
      end
    endcase
    addr_b_nxt = addr_a_nxt | (4'd1 << s_nxt);
  end

  // outputs registered from next-state so they line up with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      stage     <= '0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
    end else begin
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == DONE);
      stage     <= s_nxt;
      rd_en     <= (state_nxt == RUN);
      rd_addr_a <= (state_nxt == RUN) ? addr_a_nxt : 4'd0;
      rd_addr_b <= (state_nxt == RUN) ? addr_b_nxt : 4'd0;
      tw_addr   <= (state_nxt == RUN) ? tw_nxt : 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BF_LAT; i++) wpipe[i] <= '0;
    end else begin
      wpipe[0] <= {rd_en, rd_addr_a, rd_addr_b};
      for (int i = 1; i < BF_LAT; i++) wpipe[i] <= wpipe[i-1];
    end
  end

  assign {wr_en, wr_addr_a, wr_addr_b} = wpipe[BF_LAT-1];

endmodule

// File: tb/tb_fft16_addr_ctrl.sv
// Bench for fft16_addr_ctrl: three instances (BF_LAT = 1, 2, 5) share clock, reset and start.
// A reference model schedules every read, write and done event per accepted start;
// a negedge monitor pops and compares those events against what each instance drives.
module tb_fft16_addr_ctrl;

  logic clk;
  logic rst_n;
  logic start;

  logic [2:0] busy_w, done_w, rd_en_w, wr_en_w;
  logic [1:0] stage_w [3];
  logic [3:0] rda_w [3];
  logic [3:0] rdb_w [3];
  logic [2:0] tw_w [3];
  logic [3:0] wra_w [3];
  logic [3:0] wrb_w [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fft16_addr_ctrl #(.BF_LAT(g == 0 ? 1 : (g == 1 ? 2 : 5))) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .busy      (busy_w[g]),
      .done      (done_w[g]),
      .stage     (stage_w[g]),
      .rd_en     (rd_en_w[g]),
      .rd_addr_a (rda_w[g]),
      .rd_addr_b (rdb_w[g]),
      .tw_addr   (tw_w[g]),
      .wr_en     (wr_en_w[g]),
      .wr_addr_a (wra_w[g]),
      .wr_addr_b (wrb_w[g])
    );
  end

  typedef struct {
    int cyc;
    int a;
    int b;
    int tw;
    int st;
  } ev_t;

  ev_t rdq [3][$];
  ev_t wrq [3][$];
  int  doneq [3][$];
  int  busy_lo [3];
  int  busy_hi [3];
  int  last_done [3];

  int cyc;
  int checks;
  int errors;

  function automatic int lat_of(int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 5);
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic fail(string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Reference model: schedule of one FFT started at edge e (RUN from interval e).
  task automatic accept(int i, int e);
    int l, half, pos, grp, c;
    ev_t ev, we;
    l = lat_of(i);
    for (int s = 0; s < 4; s++) begin
      for (int b = 0; b < 8; b++) begin
        half  = 1 << s;
        pos   = b % half;
        grp   = b / half;
        c     = e + s * (8 + l) + b;
        ev.cyc = c;
        ev.a   = grp * 2 * half + pos;
        ev.b   = ev.a + half;
        ev.tw  = (pos << (3 - s)) % 8;
        ev.st  = s;
        rdq[i].push_back(ev);
        we     = ev;
        we.cyc = c + l;
        wrq[i].push_back(we);
      end
    end
    doneq[i].push_back(e + 4 * (8 + l));
    busy_lo[i]   = e;
    busy_hi[i]   = e + 4 * (8 + l);
    last_done[i] = e + 4 * (8 + l);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 3; i++) begin
      busy_lo[i] = 1;
      busy_hi[i] = 0;
      last_done[i] = -100;
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        // DONE at last_done, IDLE the interval after, so start accepted from last_done+2
        if (start && cyc > last_done[i] + 1) accept(i, cyc);
      end
    end
  end

  always @(negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      rdq[i].delete();
      wrq[i].delete();
      doneq[i].delete();
      busy_lo[i] = 1;
      busy_hi[i] = 0;
      last_done[i] = -100;
    end
  end

  // monitor
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int l;
      ev_t e;
      l = lat_of(i);
      chk($sformatf("L%0d busy @%0d", l, cyc), int'(busy_w[i]),
          int'(cyc >= busy_lo[i] && cyc <= busy_hi[i]));

      while (rdq[i].size() > 0 && rdq[i][0].cyc < cyc) begin
        fail($sformatf("L%0d missed rd @%0d", l, rdq[i][0].cyc));
        void'(rdq[i].pop_front());
      end
      if (rd_en_w[i]) begin
        if (rdq[i].size() > 0 && rdq[i][0].cyc == cyc) begin
          e = rdq[i].pop_front();
          chk($sformatf("L%0d rd_addr_a @%0d", l, cyc), int'(rda_w[i]), e.a);
          chk($sformatf("L%0d rd_addr_b @%0d", l, cyc), int'(rdb_w[i]), e.b);
          chk($sformatf("L%0d tw_addr @%0d", l, cyc), int'(tw_w[i]), e.tw);
          chk($sformatf("L%0d stage @%0d", l, cyc), int'(stage_w[i]), e.st);
        end else begin
          fail($sformatf("L%0d unexpected rd_en @%0d", l, cyc));
        end
      end else begin
        chk($sformatf("L%0d idle rd addrs @%0d", l, cyc),
            int'(rda_w[i]) + int'(rdb_w[i]) + int'(tw_w[i]), 0);
      end

      while (wrq[i].size() > 0 && wrq[i][0].cyc < cyc) begin
        fail($sformatf("L%0d missed wr @%0d", l, wrq[i][0].cyc));
        void'(wrq[i].pop_front());
      end
      if (wr_en_w[i]) begin
        if (wrq[i].size() > 0 && wrq[i][0].cyc == cyc) begin
          e = wrq[i].pop_front();
          chk($sformatf("L%0d wr_addr_a @%0d", l, cyc), int'(wra_w[i]), e.a);
          chk($sformatf("L%0d wr_addr_b @%0d", l, cyc), int'(wrb_w[i]), e.b);
        end else begin
          fail($sformatf("L%0d unexpected wr_en @%0d", l, cyc));
        end
      end else begin
        chk($sformatf("L%0d idle wr addrs @%0d", l, cyc),
            int'(wra_w[i]) + int'(wrb_w[i]), 0);
      end

      while (doneq[i].size() > 0 && doneq[i][0] < cyc) begin
        fail($sformatf("L%0d missed done @%0d", l, doneq[i][0]));
        void'(doneq[i].pop_front());
      end
      if (done_w[i]) begin
        if (doneq[i].size() > 0 && doneq[i][0] == cyc) begin
          chk($sformatf("L%0d done cycle", l), cyc, doneq[i].pop_front());
        end else begin
          fail($sformatf("L%0d unexpected done @%0d", l, cyc));
        end
      end
    end
  end

  task automatic chk_all_zero(string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s L%0d busy", tag, lat_of(i)), int'(busy_w[i]), 0);
      chk($sformatf("%s L%0d done", tag, lat_of(i)), int'(done_w[i]), 0);
      chk($sformatf("%s L%0d rd_en", tag, lat_of(i)), int'(rd_en_w[i]), 0);
      chk($sformatf("%s L%0d wr_en", tag, lat_of(i)), int'(wr_en_w[i]), 0);
      chk($sformatf("%s L%0d stage", tag, lat_of(i)), int'(stage_w[i]), 0);
      chk($sformatf("%s L%0d addrs", tag, lat_of(i)),
          int'(rda_w[i]) + int'(rdb_w[i]) + int'(tw_w[i]) + int'(wra_w[i]) + int'(wrb_w[i]), 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // single start pulse, full run
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (70) @(posedge clk);

    // start held high across runs, back-to-back restarts
    #1 start = 1'b1;
    repeat (130) @(posedge clk);
    #1 start = 1'b0;
    repeat (70) @(posedge clk);

    // random start pulses, including mid-run ones that must be ignored
    for (int k = 0; k < 300; k++) begin
      #1 start = ($urandom_range(0, 9) == 0);
      @(posedge clk);
    end
    #1 start = 1'b0;
    repeat (80) @(posedge clk);

    // reset during stage 2 of the BF_LAT=2 instance with writes in flight
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (23) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk_all_zero("async reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (25) @(posedge clk);

    // recovery run after reset
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (70) @(posedge clk);

    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("L%0d pending rd at end", lat_of(i)), rdq[i].size(), 0);
      chk($sformatf("L%0d pending wr at end", lat_of(i)), wrq[i].size(), 0);
      chk($sformatf("L%0d pending done at end", lat_of(i)), doneq[i].size(), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
